// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline types for the hazard controller.
// In-flight table entry layout, depth limits and forward-select codes.
package pipe_hazard_ctrl_pkg;

  localparam int DEPTH_MIN = 2;
  localparam int DEPTH_MAX = 8;
  localparam int IDX_MAX   = 8;
  localparam int SEL_RF    = 0;

  // Register indices are zero-extended to IDX_MAX inside the table.
  typedef logic [IDX_MAX-1:0] idx_t;

  typedef struct packed {
    logic valid;
    idx_t src1;
    idx_t src2;
    logic two_src;
    idx_t dest;
    logic wb_en;
    logic mem_r_en;
  } ent_t;

  function automatic logic src_hit(
    input ent_t e,
    input idx_t s1,
    input idx_t s2,
    input logic two
  );
    return e.valid && e.wb_en &&
           ((e.dest == s1) || (two && (e.dest == s2)));
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_select.sv
// Priority match of one EXE source index against older entries.
// The youngest producer (smallest entry index) wins.
module pipe_fwd_select
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int SEL_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:1] wr_v,
  input  idx_t [DEPTH-1:1] wr_dest,
  input  idx_t             src,
  input  logic             en,
  output logic [SEL_W-1:0] sel
);

  always_comb begin
    sel = SEL_W'(SEL_RF);
    if (en) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        if (wr_v[k] && (wr_dest[k] == src)) begin
          sel = SEL_W'(k);
        end
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard detection, stall/flush control and operand forwarding select.
// Tracks DEPTH in-flight instructions from EXE through WB.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_W = 4,
  parameter int DEPTH = 3,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     forward_en,
  input  logic                     issue_valid,
  input  logic [REG_W-1:0]         issue_src1,
  input  logic [REG_W-1:0]         issue_src2,
  input  logic [REG_W-1:0]         issue_dest,
  input  logic                     issue_two_src,
  input  logic                     issue_wb_en,
  input  logic                     issue_mem_r_en,
  input  logic                     branch_taken,
  input  logic                     mem_ready,
  output logic                     freeze,
  output logic                     flush,
  output logic                     stall_all,
  output logic [$clog2(DEPTH)-1:0] fwd_sel1,
  output logic [$clog2(DEPTH)-1:0] fwd_sel2,
  output logic [CNT_W-1:0]         hz_cnt,
  output logic [CNT_W-1:0]         stall_cnt
);

  localparam int SEL_W = $clog2(DEPTH);

  ent_t [DEPTH-1:0] tbl_q, tbl_d;
  logic [CNT_W-1:0] hz_q, hz_d;
  logic [CNT_W-1:0] st_q, st_d;

  ent_t issue_ent;
  idx_t is1, is2;
  logic hazard;

  always_comb begin
    is1 = idx_t'(issue_src1);
    is2 = idx_t'(issue_src2);
    issue_ent = '0;
    issue_ent.valid    = 1'b1;
    issue_ent.src1     = is1;
    issue_ent.src2     = is2;
    issue_ent.two_src  = issue_two_src;
    issue_ent.dest     = idx_t'(issue_dest);
    issue_ent.wb_en    = issue_wb_en;
    issue_ent.mem_r_en = issue_mem_r_en;
  end

  // WB (last entry) is assumed to write the register file early enough.
  always_comb begin
    hazard = 1'b0;
    if (forward_en) begin
      hazard = tbl_q[0].mem_r_en &&
               src_hit(tbl_q[0], is1, is2, issue_two_src);
    end else begin
      for (int k = 0; k < DEPTH - 1; k++) begin
        if (src_hit(tbl_q[k], is1, is2, issue_two_src)) begin
          hazard = 1'b1;
        end
      end
    end
  end

  always_comb begin
    tbl_d = tbl_q;
    if (mem_ready) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        tbl_d[k] = tbl_q[k-1];
      end
      tbl_d[0] = '0;
      if (issue_valid && !hazard && !branch_taken) begin
        tbl_d[0] = issue_ent;
      end
    end
  end

  always_comb begin
    hz_d = hz_q;
    st_d = st_q;
    if (issue_valid && hazard && mem_ready && (hz_q != '1)) begin
      hz_d = hz_q + CNT_W'(1);
    end
    if (!mem_ready && (st_q != '1)) begin
      st_d = st_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tbl_q <= '0;
      hz_q  <= '0;
      st_q  <= '0;
    end else begin
      tbl_q <= tbl_d;
      hz_q  <= hz_d;
      st_q  <= st_d;
    end
  end

  logic [DEPTH-1:1] wr_v;
  idx_t [DEPTH-1:1] wr_dest;
  logic             en1, en2;
  logic [SEL_W-1:0] sel1, sel2;
  logic             unused_tbl;

  always_comb begin
    unused_tbl = 1'b0;
    for (int k = 1; k < DEPTH; k++) begin
      wr_v[k]    = tbl_q[k].valid && tbl_q[k].wb_en;
      wr_dest[k] = tbl_q[k].dest;
      unused_tbl = unused_tbl ^ (^{tbl_q[k].src1, tbl_q[k].src2,
                                   tbl_q[k].two_src,
                                   tbl_q[k].mem_r_en});
    end
    en1 = forward_en && tbl_q[0].valid;
    en2 = en1 && tbl_q[0].two_src;
  end

  pipe_fwd_select #(.DEPTH(DEPTH), .SEL_W(SEL_W)) u_fwd1 (
    .wr_v    (wr_v),
    .wr_dest (wr_dest),
    .src     (tbl_q[0].src1),
    .en      (en1),
    .sel     (sel1)
  );

  pipe_fwd_select #(.DEPTH(DEPTH), .SEL_W(SEL_W)) u_fwd2 (
    .wr_v    (wr_v),
    .wr_dest (wr_dest),
    .src     (tbl_q[0].src2),
    .en      (en2),
    .sel     (sel2)
  );

  // Reset forces every control output low, not just the state.
  always_comb begin
    stall_all = rst && !mem_ready;
    freeze    = rst && (!mem_ready || (issue_valid && hazard));
    flush     = rst && branch_taken && mem_ready;
    fwd_sel1  = rst ? sel1 : '0;
    fwd_sel2  = rst ? sel2 : '0;
  end

  assign hz_cnt    = hz_q;
  assign stall_cnt = st_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl (DEPTH=3, CNT_W=4).
// Driver queues hand-computed expectations; monitor checks each cycle.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       forward_en = 1'b0;
  logic       issue_valid = 1'b0;
  logic [3:0] issue_src1 = '0, issue_src2 = '0, issue_dest = '0;
  logic       issue_two_src = 1'b0, issue_wb_en = 1'b0;
  logic       issue_mem_r_en = 1'b0;
  logic       branch_taken = 1'b0;
  logic       mem_ready = 1'b1;
  logic       freeze, flush, stall_all;
  logic [1:0] fwd_sel1, fwd_sel2;
  logic [3:0] hz_cnt, stall_cnt;

  typedef struct packed {
    logic       frz;
    logic       fl;
    logic       st;
    logic [1:0] f1;
    logic [1:0] f2;
    logic [3:0] hz;
    logic [3:0] sc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   vec = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_W(4), .DEPTH(3), .CNT_W(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .forward_en     (forward_en),
    .issue_valid    (issue_valid),
    .issue_src1     (issue_src1),
    .issue_src2     (issue_src2),
    .issue_dest     (issue_dest),
    .issue_two_src  (issue_two_src),
    .issue_wb_en    (issue_wb_en),
    .issue_mem_r_en (issue_mem_r_en),
    .branch_taken   (branch_taken),
    .mem_ready      (mem_ready),
    .freeze         (freeze),
    .flush          (flush),
    .stall_all      (stall_all),
    .fwd_sel1       (fwd_sel1),
    .fwd_sel2       (fwd_sel2),
    .hz_cnt         (hz_cnt),
    .stall_cnt      (stall_cnt)
  );

  function automatic exp_t E(input logic frz, input logic fl,
                             input logic st, input int f1, input int f2,
                             input int hz, input int sc);
    exp_t e;
    e.frz = frz;
    e.fl  = fl;
    e.st  = st;
    e.f1  = 2'(f1);
    e.f2  = 2'(f2);
    e.hz  = 4'(hz);
    e.sc  = 4'(sc);
    return e;
  endfunction

  task automatic chk(input string nm, input int act, input int ex,
                     input int v);
    checks++;
    if (act != ex) begin
      errors++;
      $display("FAIL %s vec %0d: got %0d expected %0d", nm, v, act, ex);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("freeze", int'(freeze), int'(e.frz), vec);
      chk("flush", int'(flush), int'(e.fl), vec);
      chk("stall_all", int'(stall_all), int'(e.st), vec);
      chk("fwd_sel1", int'(fwd_sel1), int'(e.f1), vec);
      chk("fwd_sel2", int'(fwd_sel2), int'(e.f2), vec);
      chk("hz_cnt", int'(hz_cnt), int'(e.hz), vec);
      chk("stall_cnt", int'(stall_cnt), int'(e.sc), vec);
      vec++;
    end
  end

  task automatic step(input logic r, input logic fe, input logic iv,
                      input int s1, input int s2, input int d,
                      input logic two, input logic wb, input logic ld,
                      input logic bt, input logic rdy, input exp_t e);
    @(posedge clk);
    #1;
    rst            = r;
    forward_en     = fe;
    issue_valid    = iv;
    issue_src1     = 4'(s1);
    issue_src2     = 4'(s2);
    issue_dest     = 4'(d);
    issue_two_src  = two;
    issue_wb_en    = wb;
    issue_mem_r_en = ld;
    branch_taken   = bt;
    mem_ready      = rdy;
    sb.push_back(e);
  endtask

  task automatic ins(input logic fe, input int s1, input int s2,
                     input int d, input logic two, input logic ld,
                     input exp_t e);
    step(1'b1, fe, 1'b1, s1, s2, d, two, 1'b1, ld, 1'b0, 1'b1, e);
  endtask

  task automatic idle(input logic fe, input exp_t e);
    step(1'b1, fe, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, e);
  endtask

  initial begin
    // reset: everything forced low even with stall/branch requested
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, E(0, 0, 0, 0, 0, 0, 0));
    step(0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, E(0, 0, 0, 0, 0, 0, 0));

    // forwarding: ADD R1 ; SUB R2,R1,R3
    ins(1, 2, 3, 1, 1, 0, E(0, 0, 0, 0, 0, 0, 0));
    ins(1, 1, 3, 2, 1, 0, E(0, 0, 0, 0, 0, 0, 0));
    idle(1, E(0, 0, 0, 1, 0, 0, 0));
    idle(1, E(0, 0, 0, 0, 0, 0, 0));
    idle(1, E(0, 0, 0, 0, 0, 0, 0));

    // stall-only: same pair, two hazard cycles
    ins(0, 2, 3, 1, 1, 0, E(0, 0, 0, 0, 0, 0, 0));
    ins(0, 1, 3, 2, 1, 0, E(1, 0, 0, 0, 0, 0, 0));
    ins(0, 1, 3, 2, 1, 0, E(1, 0, 0, 0, 0, 1, 0));
    ins(0, 1, 3, 2, 1, 0, E(0, 0, 0, 0, 0, 2, 0));
    idle(0, E(0, 0, 0, 0, 0, 2, 0));
    idle(0, E(0, 0, 0, 0, 0, 2, 0));
    idle(0, E(0, 0, 0, 0, 0, 2, 0));

    // load-use: LDR R4 ; ADD R5,R4,R6
    ins(1, 2, 0, 4, 0, 1, E(0, 0, 0, 0, 0, 2, 0));
    ins(1, 4, 6, 5, 1, 0, E(1, 0, 0, 0, 0, 2, 0));
    ins(1, 4, 6, 5, 1, 0, E(0, 0, 0, 0, 0, 3, 0));
    idle(1, E(0, 0, 0, 2, 0, 3, 0));
    idle(1, E(0, 0, 0, 0, 0, 3, 0));
    idle(1, E(0, 0, 0, 0, 0, 3, 0));

    // memory stall with pending taken branch, then deferred flush
    ins(1, 1, 2, 7, 1, 0, E(0, 0, 0, 0, 0, 3, 0));
    ins(1, 7, 7, 8, 1, 0, E(0, 0, 0, 0, 0, 3, 0));
    for (int i = 0; i < 3; i++)
      step(1, 1, 1, 8, 0, 11, 0, 1, 0, 1, 0, E(1, 0, 1, 1, 1, 3, i));
    step(1, 1, 1, 8, 0, 11, 0, 1, 0, 1, 1, E(0, 1, 0, 1, 1, 3, 3));
    idle(1, E(0, 0, 0, 0, 0, 3, 3));
    idle(1, E(0, 0, 0, 0, 0, 3, 3));

    // youngest producer wins; src2 masked when two_src=0
    ins(1, 0, 0, 9, 0, 0, E(0, 0, 0, 0, 0, 3, 3));
    ins(1, 0, 0, 9, 0, 0, E(0, 0, 0, 0, 0, 3, 3));
    ins(1, 1, 9, 10, 1, 0, E(0, 0, 0, 0, 0, 3, 3));
    idle(1, E(0, 0, 0, 0, 1, 3, 3));
    ins(1, 0, 10, 11, 0, 0, E(0, 0, 0, 0, 0, 3, 3));
    idle(1, E(0, 0, 0, 0, 0, 3, 3));

    // long stall saturates the 4-bit stall counter
    for (int i = 0; i < 20; i++)
      step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,
           E(1, 0, 1, 0, 0, 3, (3 + i > 15) ? 15 : 3 + i));

    // reset mid-stall takes effect immediately
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E(0, 0, 0, 0, 0, 0, 0));
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, E(0, 0, 0, 0, 0, 0, 0));

    // table was emptied: old R11 producer no longer causes a stall
    ins(0, 11, 0, 3, 0, 0, E(0, 0, 0, 0, 0, 0, 0));
    ins(0, 3, 0, 4, 0, 0, E(1, 0, 0, 0, 0, 0, 0));
    idle(0, E(0, 0, 0, 0, 0, 1, 0));

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0",
               sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
